// File: rtl/branch_predictor.sv
// branch_predictor: bimodal direction predictor. It uses a table of 2-bit
// saturating counters indexed by pc[INDEX_BITS+1:2]. It also produces a
// registered fetch redirect on a mispredict and keeps saturating statistics
// counters.

// One table entry: a 2-bit saturating up/down counter.
module bp_ctr #(
   parameter logic [1:0] CTR_INIT = 2'b01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       dec,
   output logic [1:0] ctr
);

   // inc and dec are never both set; each stops at its end of the range.
   always_ff @(posedge clk) begin
      if (rst)                      ctr <= CTR_INIT;
      else if (inc && ctr != 2'b11) ctr <= ctr + 2'd1;
      else if (dec && ctr != 2'b00) ctr <= ctr - 2'd1;
   end

endmodule

module branch_predictor #(
   parameter int         INDEX_BITS = 5,
   parameter logic [1:0] CTR_INIT   = 2'b01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pred_pc,
   output logic        pred_taken,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_br_en,
   input  logic        upd_pred,
   input  logic [31:0] upd_target,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
);

   localparam int DEPTH = 1 << INDEX_BITS;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        br_en;
      logic        pred;
      logic [31:0] target;
   } upd_req_t;

   upd_req_t                  upd;
   logic [INDEX_BITS-1:0]     pred_idx;
   logic [INDEX_BITS-1:0]     upd_idx;
   logic [DEPTH-1:0][1:0]     table_q;
   logic                      mispredict;
   logic [31:0]               fix_pc;

   assign upd      = '{valid: upd_valid, pc: upd_pc, br_en: upd_br_en,
                       pred: upd_pred, target: upd_target};
   assign pred_idx = pred_pc[INDEX_BITS+1:2];
   assign upd_idx  = upd.pc[INDEX_BITS+1:2];

   // The lookup reads the registered table directly. A same-cycle update
   // to the same entry is therefore not visible until the next cycle.
   assign pred_taken = table_q[pred_idx][1];

   // Each entry has its own counter instance and its own hit decode.
   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      localparam logic [INDEX_BITS-1:0] IDX = INDEX_BITS'(g);
      logic hit;
      assign hit = upd.valid && (upd_idx == IDX);
      bp_ctr #(.CTR_INIT(CTR_INIT)) u_ctr (
         .clk (clk),
         .rst (rst),
         .inc (hit &  upd.br_en),
         .dec (hit & ~upd.br_en),
         .ctr (table_q[g])
      );
   end

   assign mispredict = upd.valid && (upd.br_en != upd.pred);
   // A taken branch resumes at its target; a not-taken branch resumes at
   // the fall-through address. The +4 wraps naturally in 32 bits.
   assign fix_pc     = upd.br_en ? upd.target : upd.pc + 32'd4;

   // The redirect pulse lasts one cycle. The PC is captured only on a
   // mispredict and holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         redirect <= mispredict;
         if (mispredict) redirect_pc <= fix_pc;
      end
   end

   // Statistics counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (upd.valid && branch_count != '1)     branch_count     <= branch_count + 32'd1;
         if (mispredict && mispredict_count != '1) mispredict_count <= mispredict_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_br_en;
   logic        upd_pred;
   logic [31:0] upd_target;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   int total = 0;
   int bad   = 0;

   branch_predictor dut (
      .clk              (clk),
      .rst              (rst),
      .pred_pc          (pred_pc),
      .pred_taken       (pred_taken),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_br_en        (upd_br_en),
      .upd_pred         (upd_pred),
      .upd_target       (upd_target),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are stable 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic v, input logic [31:0] pc, input logic br,
                          input logic pr, input logic [31:0] tgt);
      upd_valid  = v;
      upd_pc     = pc;
      upd_br_en  = br;
      upd_pred   = pr;
      upd_target = tgt;
   endtask

   task automatic do_reset();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      pred_pc = 32'h100;
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b want=0", pred_taken); end
      total++; if (branch_count !== 32'h0) begin bad++; $display("FAIL reset_bcnt got=%h want=0", branch_count); end
      total++; if (mispredict_count !== 32'h0) begin bad++; $display("FAIL reset_mcnt got=%h want=0", mispredict_count); end
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redir got=%b want=0", redirect); end
      total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_rpc got=%h want=0", redirect_pc); end
      pred_pc = 32'h7C;
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_idx31 got=%b want=0", pred_taken); end
   endtask

   // 01 -> 10 -> 11 -> 11. Then one decrement must land on 10, which
   // proves the counter stuck at 11. A correct not-taken prediction then
   // brings it to 01.
   task automatic test_taken_saturate();
      do_reset();
      pred_pc = 32'h100;
      set_upd(1'b1, 32'h100, 1'b1, 1'b0, 32'h4000);
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL taken_pred_%0d got=%b want=1", i, pred_taken); end
         total++; if (redirect !== 1'b1 || redirect_pc !== 32'h4000) begin bad++; $display("FAIL taken_redir_%0d got=%b/%h want=1/00004000", i, redirect, redirect_pc); end
      end
      total++; if (mispredict_count !== 32'd3 || branch_count !== 32'd3) begin bad++; $display("FAIL taken_counts got=%0d/%0d want=3/3", branch_count, mispredict_count); end
      set_upd(1'b1, 32'h100, 1'b0, 1'b1, 32'h4000);
      tick();
      total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_dec_pred got=%b want=1", pred_taken); end
      total++; if (redirect !== 1'b1 || redirect_pc !== 32'h104) begin bad++; $display("FAIL sat_dec_redir got=%b/%h want=1/00000104", redirect, redirect_pc); end
      set_upd(1'b1, 32'h100, 1'b0, 1'b0, 32'h4000);
      tick();
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL dec2_pred got=%b want=0", pred_taken); end
      total++; if (redirect !== 1'b0 || redirect_pc !== 32'h104) begin bad++; $display("FAIL correct_pred_redir got=%b/%h want=0/00000104", redirect, redirect_pc); end
      total++; if (branch_count !== 32'd5 || mispredict_count !== 32'd4) begin bad++; $display("FAIL dec_counts got=%0d/%0d want=5/4", branch_count, mispredict_count); end
   endtask

   task automatic test_not_taken_redirect();
      do_reset();
      set_upd(1'b1, 32'h200, 1'b0, 1'b1, 32'h8000);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      total++; if (redirect !== 1'b1 || redirect_pc !== 32'h204) begin bad++; $display("FAIL nt_redir got=%b/%h want=1/00000204", redirect, redirect_pc); end
      tick();
      total++; if (redirect !== 1'b0 || redirect_pc !== 32'h204) begin bad++; $display("FAIL nt_redir_drop got=%b/%h want=0/00000204", redirect, redirect_pc); end
      pred_pc = 32'h200;
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL nt_pred got=%b want=0", pred_taken); end
   endtask

   // Two mispredicts in a row. The second one also covers the +4 wrap.
   task automatic test_back_to_back();
      do_reset();
      set_upd(1'b1, 32'h200, 1'b0, 1'b1, 32'h8000);
      tick();
      set_upd(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h8000);
      total++; if (redirect !== 1'b1 || redirect_pc !== 32'h204) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/00000204", redirect, redirect_pc); end
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      total++; if (redirect !== 1'b1 || redirect_pc !== 32'h0) begin bad++; $display("FAIL b2b_wrap got=%b/%h want=1/00000000", redirect, redirect_pc); end
      tick();
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b want=0", redirect); end
      total++; if (mispredict_count !== 32'd2) begin bad++; $display("FAIL b2b_mcnt got=%0d want=2", mispredict_count); end
   endtask

   task automatic test_same_index_no_bypass();
      do_reset();
      pred_pc = 32'h300;
      set_upd(1'b1, 32'h300, 1'b1, 1'b0, 32'h1000);
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL bypass_same_cycle got=%b want=0", pred_taken); end
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL bypass_next got=%b want=1", pred_taken); end
      pred_pc = 32'h83;
      #1;
      total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alias got=%b want=1", pred_taken); end
      pred_pc = 32'h304;
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL neighbor got=%b want=0", pred_taken); end
   endtask

   task automatic test_invalid_no_update();
      do_reset();
      pred_pc = 32'h104;
      set_upd(1'b0, 32'h104, 1'b1, 1'b0, 32'h2000);
      tick();
      tick();
      tick();
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL inv_pred got=%b want=0", pred_taken); end
      total++; if (branch_count !== 32'h0 || redirect !== 1'b0) begin bad++; $display("FAIL inv_state got=%h/%b want=0/0", branch_count, redirect); end
   endtask

   task automatic test_rst_priority();
      do_reset();
      set_upd(1'b1, 32'h108, 1'b1, 1'b0, 32'h3000);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      pred_pc = 32'h108;
      #1;
      total++; if (branch_count !== 32'h0 || mispredict_count !== 32'h0) begin bad++; $display("FAIL rstpri_counts got=%h/%h want=0/0", branch_count, mispredict_count); end
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL rstpri_redir got=%b want=0", redirect); end
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL rstpri_pred got=%b want=0", pred_taken); end
      tick();
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL rstpri_redir2 got=%b want=0", redirect); end
   endtask

   task automatic test_count_saturate();
      do_reset();
      force dut.branch_count     = 32'hFFFF_FFFF;
      force dut.mispredict_count = 32'hFFFF_FFFF;
      #1;
      release dut.branch_count;
      release dut.mispredict_count;
      set_upd(1'b1, 32'h10C, 1'b1, 1'b0, 32'h5000);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      total++; if (branch_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_bcnt got=%h want=ffffffff", branch_count); end
      total++; if (mispredict_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_mcnt got=%h want=ffffffff", mispredict_count); end
   endtask

   initial begin
      rst     = 1'b1;
      pred_pc = 32'h0;
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      test_reset();
      test_taken_saturate();
      test_not_taken_redirect();
      test_back_to_back();
      test_same_index_no_bypass();
      test_invalid_no_update();
      test_rst_priority();
      test_count_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
